// File: rtl/riscv_soc_pkg.sv
// Shared address map, MMIO register offsets and store-FSM encoding for the core's data side.
package riscv_soc_pkg;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

    // Word offsets within the 16-byte MMIO page (mem_addr[3:2]).
    localparam logic [1:0] MMIO_TXDATA = 2'd0;
    localparam logic [1:0] MMIO_STATUS = 2'd1;
    localparam logic [1:0] MMIO_CYC_LO = 2'd2;
    localparam logic [1:0] MMIO_CYC_HI = 2'd3;

    localparam int unsigned STAT_TX_VALID = 0;
    localparam int unsigned STAT_OVERRUN  = 1;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StCommit
    } wr_state_e;

endpackage

// File: rtl/riscv_dmem_ram.sv
// Word-wide data RAM: asynchronous read, single synchronous write port. Contents are not reset.
module riscv_dmem_ram #(
    parameter int unsigned DEPTH_W = 1024,
    localparam int unsigned AW     = $clog2(DEPTH_W)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-port slave of riscv_core: RAM/MMIO decode, 2-cycle store FSM, UART TX register and
// free-running 64-bit cycle counter.
module riscv_dmem_ctrl
    import riscv_soc_pkg::*;
#(
    parameter int unsigned DEPTH_W   = 1024,
    parameter logic [31:0] RAM_BASE  = riscv_soc_pkg::RAM_BASE,
    parameter logic [31:0] MMIO_BASE = riscv_soc_pkg::MMIO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] ddatout,
    input  logic        en,
    input  logic        rw,
    output logic [31:0] ddatin,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);

    localparam int unsigned AW      = $clog2(DEPTH_W);
    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(4 * DEPTH_W);

    wr_state_e   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        overrun_q, overrun_d;
    logic        bus_err_q, bus_err_d;
    logic [63:0] cyc_q, cyc_d;

    logic          ram_hit, mmio_hit, commit, ram_we, handshake;
    logic [1:0]    mmio_off;
    logic [AW-1:0] word_idx;
    logic [31:0]   ram_rdata, status;

    assign ram_hit  = ({1'b0, mem_addr} >= {1'b0, RAM_BASE}) && ({1'b0, mem_addr} < RAM_END);
    assign mmio_hit = !ram_hit && (mem_addr[31:4] == MMIO_BASE[31:4]);
    assign mmio_off = mem_addr[3:2];
    assign word_idx = mem_addr[AW+1:2];

    // The RAM has no reset, so a commit coinciding with a reset edge must be gated here.
    assign ram_we    = commit && ram_hit && rst;
    assign handshake = tx_valid_q && tx_ready;

    riscv_dmem_ram #(
        .DEPTH_W(DEPTH_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(word_idx),
        .wdata(ddatout),
        .raddr(word_idx),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle:   if (en && rw) state_d = StArm;
            StArm: begin
                if (en && rw) begin
                    state_d = StCommit;
                    commit  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StCommit: if (!(en && rw)) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q && !handshake;
        overrun_d  = overrun_q;
        bus_err_d  = commit && !ram_hit && !mmio_hit;
        cyc_d      = cyc_q + 64'd1;
        if (commit && mmio_hit) begin
            if (mmio_off == MMIO_TXDATA) begin
                if (!tx_valid_q || handshake) begin
                    tx_data_d  = ddatout[7:0];
                    tx_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else if (mmio_off == MMIO_STATUS) begin
                overrun_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            cyc_q      <= 64'd0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overrun_q  <= overrun_d;
            bus_err_q  <= bus_err_d;
            cyc_q      <= cyc_d;
        end
    end

    always_comb begin
        status                = '0;
        status[STAT_TX_VALID] = tx_valid_q;
        status[STAT_OVERRUN]  = overrun_q;
    end

    always_comb begin
        ddatin = 32'h0;
        if (en) begin
            if (ram_hit) begin
                ddatin = ram_rdata;
            end else if (mmio_hit) begin
                unique case (mmio_off)
                    MMIO_TXDATA: ddatin = 32'h0;
                    MMIO_STATUS: ddatin = status;
                    MMIO_CYC_LO: ddatin = cyc_q[31:0];
                    MMIO_CYC_HI: ddatin = cyc_q[63:32];
                    default:     ddatin = 32'h0;
                endcase
            end
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign bus_err  = bus_err_q;

endmodule
